i2c_dac_sequencer: RTL and testbench

I2C_DAC_SEQUENCER -- requirements
Module: i2c_dac_sequencer

---
 rtl/i2c_dac_pkg.sv | 10 +
 rtl/i2c_cmd_fifo.sv | 46 ++++
 rtl/i2c_dac_sequencer.sv | 142 ++++++++++++++
 tb/tb_i2c_dac_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_dac_pkg.sv
// Shared types and constants for the I2C DAC command sequencer.
package i2c_dac_pkg;

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, GAP} state_t;

  localparam logic [3:0] CMD_NIBBLE   = 4'b0011;
  localparam logic [3:0] BCAST_CH     = 4'hF;
  localparam int         FRAME_PHASES = 156;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous first-word-fall-through queue; pushes while full are dropped.
module i2c_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;

  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: registers use <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/i2c_dac_sequencer.sv
// Queues DAC commands and emits each as a 4-byte I2C write frame with ACK checking.
module i2c_dac_sequencer
  import i2c_dac_pkg::*;
#(
  parameter int         CLK_DIV    = 25,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [6:0] ADDR_BASE  = 7'b0001100,
  parameter int         VOL_W      = 12
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_chip,
  input  logic [3:0]       cmd_ch,
  input  logic [VOL_W-1:0] cmd_vol,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             sda_in,
  output logic             busy,
  output logic             done,
  output logic             nack_err
);

  localparam int CMD_W = 1 + 4 + VOL_W;
  localparam int DW    = $clog2(CLK_DIV);

  logic [CMD_W-1:0] q_data;
  logic             q_full;
  logic             q_empty;
  logic             pop;

  state_t           state;
  logic [DW-1:0]    div_cnt;
  logic [1:0]       phase;
  logic [2:0]       bit_cnt;
  logic [1:0]       byte_cnt;
  logic [31:0]      shreg;
  logic             nack_q;
  logic             phase_end;
  logic             slot_end;
  logic [15:0]      vol16;
  logic [31:0]      frame;

  assign pop       = (state == IDLE) && !q_empty;
  assign cmd_ready = !q_full;
  assign busy      = (state != IDLE) || !q_empty;

  i2c_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .wr_en    (cmd_valid),
    .wr_data  ({cmd_chip, cmd_ch, cmd_vol}),
    .full     (q_full),
    .rd_en    (pop),
    .rd_data  (q_data),
    .empty    (q_empty)
  );

  // The DAC code is left-justified into the two data bytes.
  assign vol16 = 16'(q_data[VOL_W-1:0]) << (16 - VOL_W);
  assign frame = {ADDR_BASE[6:1], q_data[CMD_W-1], 1'b0, CMD_NIBBLE, q_data[VOL_W+3:VOL_W], vol16};

  assign phase_end = (div_cnt == DW'(CLK_DIV - 1));
  assign slot_end  = phase_end && (phase == 2'd3);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state    <= IDLE;
      div_cnt  <= '0;
      phase    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      nack_q   <= 1'b0;
    end else if (state == IDLE) begin
      div_cnt <= '0;
      phase   <= '0;
      if (!q_empty) begin
        state    <= START;
        shreg    <= frame;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        nack_q   <= 1'b0;
      end
    end else begin
      div_cnt <= phase_end ? '0 : div_cnt + 1'b1;
      if (phase_end) phase <= phase + 1'b1;
      // The slave's answer is taken at the very end of the SCL-high window.
      if (state == ACK && phase == 2'd2 && phase_end) nack_q <= sda_in;
      if (slot_end) begin
        case (state)
          START: state <= BIT;
          BIT: begin
            shreg   <= {shreg[30:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ACK;
          end
          ACK: begin
            if (nack_q || byte_cnt == 2'd3) begin
              state <= STOP;
            end else begin
              state    <= BIT;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          STOP:    state <= GAP;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: both outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state)
      START: begin
        sda_oe = 1'b1;
        scl_oe = (phase == 2'd3);
      end
      BIT: begin
        sda_oe = !shreg[31];
        scl_oe = (phase == 2'd0) || (phase == 2'd3);
      end
      ACK:  scl_oe = (phase == 2'd0) || (phase == 2'd3);
      STOP: begin
        sda_oe = (phase != 2'd3);
        scl_oe = (phase == 2'd0);
      end
      default: ;
    endcase
  end

  assign done     = (state == GAP) && slot_end && !nack_q;
  assign nack_err = (state == GAP) && slot_end && nack_q;

endmodule

// File: tb/tb_i2c_dac_sequencer.sv
// Bench: bus-level I2C decoder/slave plus a command scoreboard for the DAC sequencer.
module tb_i2c_dac_sequencer;
  import i2c_dac_pkg::*;

  localparam int         CLK_DIV    = 2;
  localparam int         FIFO_DEPTH = 4;
  localparam logic [6:0] ADDR_BASE  = 7'b0001100;
  localparam int         VOL_W      = 12;

  logic        clk_in    = 1'b0;
  logic        reset_in  = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_chip  = 1'b0;
  logic [3:0]  cmd_ch    = '0;
  logic [11:0] cmd_vol   = '0;
  logic        cmd_ready, scl_oe, sda_oe, sda_in, busy, done, nack_err;
  logic        slave_low = 1'b0;

  always #5 clk_in = ~clk_in;

  assign sda_in = !(sda_oe || slave_low);

  i2c_dac_sequencer #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_BASE  (ADDR_BASE),
    .VOL_W      (VOL_W)
  ) dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_chip  (cmd_chip),
    .cmd_ch    (cmd_ch),
    .cmd_vol   (cmd_vol),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .sda_in    (sda_in),
    .busy      (busy),
    .done      (done),
    .nack_err  (nack_err)
  );

  typedef struct packed {
    int          nbytes;
    logic [31:0] data;
    int          t_start;
    int          t_stop;
  } frame_t;

  frame_t      frame_q[$];
  logic [31:0] exp_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, nack_at = -1;
  int start_cnt = 0, done_cnt = 0, nack_cnt = 0, both_cnt = 0, done_t = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1, in_frame = 1'b0;
  int bit_n = 0, nbytes = 0, t_start = 0;
  logic [7:0]  sh = '0;
  logic [31:0] data = '0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Line-level decoder and ACKing slave: bits sampled on SCL rise, START/STOP
  // recognised as SDA edges while SCL is high.
  always @(negedge clk_in) begin : monitor
    logic scl_now, sda_now;
    scl_now = !scl_oe;
    sda_now = !(sda_oe || slave_low);
    if (reset_in) begin
      slave_low = 1'b0;
      in_frame  = 1'b0;
      bit_n     = 0;
    end else begin
      if (done) begin done_cnt++; done_t = cyc; end
      if (nack_err) nack_cnt++;
      if (done && nack_err) both_cnt++;
      if (scl_now && prev_scl && (sda_now != prev_sda)) begin
        if (!sda_now) begin
          start_cnt++; in_frame = 1'b1; bit_n = 0; nbytes = 0; data = '0; t_start = cyc;
        end else if (in_frame) begin
          frame_q.push_back('{nbytes, data, t_start, cyc});
          in_frame = 1'b0;
        end
      end else if (scl_now && !prev_scl) begin
        bit_n++;
        if (bit_n <= 8) sh = {sh[6:0], sda_now};
        if (bit_n == 8) begin
          if (nbytes < 4) data[31-8*nbytes -: 8] = sh;
          nbytes++;
        end else if (bit_n == 9) begin
          bit_n = 0;
        end
      end else if (!scl_now && prev_scl) begin
        slave_low = in_frame && (bit_n == 8) && (nbytes - 1 != nack_at);
      end
    end
    prev_scl = scl_now;
    prev_sda = sda_now;
  end

  function automatic logic [31:0] model_frame(input logic chip, input logic [3:0] ch,
                                              input logic [11:0] vol);
    int b0, b1, v16;
    b0  = ((int'(ADDR_BASE) / 2) * 2 + int'(chip)) * 2;
    b1  = 48 + int'(ch);
    v16 = int'(vol) * 16;
    return 32'(b0 * (1 << 24) + b1 * (1 << 16) + v16);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic chip, input logic [3:0] ch, input logic [11:0] vol,
                      output logic accepted);
    @(negedge clk_in);
    cmd_valid = 1'b1; cmd_chip = chip; cmd_ch = ch; cmd_vol = vol;
    accepted = cmd_ready;
    if (accepted) exp_q.push_back(model_frame(chip, ch, vol));
    @(posedge clk_in);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk_in);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check("idle_in_time", 32'(n < budget), 32'd1);
  endtask

  task automatic check_next_frame(input int nack_byte, output frame_t f);
    logic [31:0] e, mask;
    int nb;
    f  = '0;
    nb = (nack_byte < 0) ? 4 : nack_byte + 1;
    check("frame_present", 32'(frame_q.size() > 0 && exp_q.size() > 0), 32'd1);
    if (frame_q.size() > 0 && exp_q.size() > 0) begin
      f    = frame_q.pop_front();
      e    = exp_q.pop_front();
      mask = 32'hFFFF_FFFF << (8 * (4 - nb));
      check("byte_count", 32'(f.nbytes), 32'(nb));
      check("frame_bytes", f.data & mask, e & mask);
    end
  endtask

  task automatic run_one(input logic chip, input logic [3:0] ch, input logic [11:0] vol,
                         input int nack_byte, output frame_t f);
    int d0, n0, s0;
    logic acc;
    d0 = done_cnt; n0 = nack_cnt; s0 = start_cnt;
    nack_at = nack_byte;
    push(chip, ch, vol, acc);
    check("accepted", 32'(acc), 32'd1);
    wait_idle(1000);
    check("start_count", 32'(start_cnt - s0), 32'd1);
    check("stop_count", 32'(frame_q.size()), 32'd1);
    check("done_pulses", 32'(done_cnt - d0), 32'((nack_byte < 0) ? 1 : 0));
    check("nack_pulses", 32'(nack_cnt - n0), 32'((nack_byte < 0) ? 0 : 1));
    check("done_with_nack", 32'(both_cnt), 32'd0);
    check_next_frame(nack_byte, f);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_t f;
    logic   acc;
    int     d0, s0, n;

    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rst_scl_oe", 32'(scl_oe), 32'd0);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_nack_err", 32'(nack_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    reset_in = 1'b0;

    run_one(1'b1, 4'h2, 12'hABC, -1, f);
    check("frame_abc", f.data, 32'h1A32_ABC0);
    // done lands on the last of the frame's 156*CLK_DIV cycles.
    check("done_latency", 32'(done_t - f.t_start), 32'(FRAME_PHASES * CLK_DIV - 1));

    run_one(1'($urandom_range(0, 1)), BCAST_CH, 12'h000, -1, f);
    check("bcast_byte1", 32'(f.data[23:16]), 32'h3F);

    run_one(1'b0, 4'h5, 12'h123, 0, f);

    for (int k = 0; k < 6; k++) begin
      int nb;
      nb = int'($urandom_range(0, 4));
      if (nb == 4) nb = -1;
      run_one(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 12'($urandom), nb, f);
    end

    // Burst from idle: the first entry is popped during the second push, so five
    // pushes fit and the sixth meets a full queue.
    nack_at = -1;
    d0 = done_cnt;
    for (int k = 0; k < 6; k++) begin
      push(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 12'($urandom), acc);
      check($sformatf("burst_ready_%0d", k), 32'(acc), 32'(k < 5));
    end
    wait_idle(2500);
    check("burst_frames", 32'(frame_q.size()), 32'd5);
    check("burst_done", 32'(done_cnt - d0), 32'd5);
    for (int k = 1; k < frame_q.size(); k++)
      check($sformatf("bus_free_%0d", k),
            32'(frame_q[k].t_start - frame_q[k-1].t_stop >= 4 * CLK_DIV), 32'd1);
    for (int k = 0; k < 5; k++) check_next_frame(-1, f);

    push(1'b1, 4'h7, 12'h5A5, acc);
    push(1'b0, 4'h1, 12'h111, acc);
    push(1'b1, 4'h3, 12'h222, acc);
    n = 0;
    while (!(in_frame && nbytes == 2 && bit_n >= 3) && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    check("reached_byte2", 32'(n < 2000), 32'd1);
    check("busy_before_reset", 32'(busy), 32'd1);
    reset_in = 1'b1;
    @(negedge clk_in);
    check("mid_rst_scl_oe", 32'(scl_oe), 32'd0);
    check("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk_in);
    reset_in = 1'b0;
    frame_q.delete();
    exp_q.delete();
    s0 = start_cnt;
    repeat (200) @(negedge clk_in);
    check("no_frame_after_reset", 32'(start_cnt - s0), 32'd0);
    check("idle_after_reset", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
